// File: rtl/memory_ctrl_pkg.sv
// Shared constants and address-to-segment mapping for the memory controller
// select logic.
package memory_ctrl_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int SEL_W_DEF  = 5;
  localparam int SEG_WORDS  = 2 ** (ADDR_W_DEF - SEL_W_DEF);

  // Segments are numbered from the top of the address space downward.
  function automatic logic [SEL_W_DEF-1:0] seg_index(input logic [ADDR_W_DEF-1:0] a);
    return ~a[ADDR_W_DEF-1 -: SEL_W_DEF];
  endfunction

endpackage

// File: rtl/memory_seg_decoder.sv
// Combinational word-address to segment-index decode, shared by the write
// and read select registers.
module memory_seg_decoder
  import memory_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  seg
);

  // Only the top SEL_W bits select a segment; the word offset is ignored.
  logic unused_offset;
  assign unused_offset = &{1'b0, addr[ADDR_W-SEL_W-1:0]};

  assign seg = ~addr[ADDR_W-1 -: SEL_W];

endmodule

// File: rtl/memory_ctrl_v1.sv
// Registered segment selects for the write-data and read-data muxes.
// Optional build macro MEMORY_CTRL_V1_CONFLICT_EN adds a write-priority conflict flag.
module memory_ctrl_v1
  import memory_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int SEL_W  = SEL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel_mux_data_in,
  output logic [SEL_W-1:0]  sel_mux_data_out,
  output logic              wr_sel_valid,
  output logic              rd_sel_valid
`ifdef MEMORY_CTRL_V1_CONFLICT_EN
  ,
  output logic              conflict
`endif
);

  logic [SEL_W-1:0] seg;
  logic             rd_go;

  memory_seg_decoder #(
    .ADDR_W (ADDR_W),
    .SEL_W  (SEL_W)
  ) u_seg_decoder (
    .addr (addr),
    .seg  (seg)
  );

`ifdef MEMORY_CTRL_V1_CONFLICT_EN
  // A coincident write wins; the read is dropped rather than deferred.
  assign rd_go = rd_en & ~wr_en;
`else
  assign rd_go = rd_en;
`endif

  // NOTE: reset is tested inside the clocked block so it is synchronous and
  // also swallows any enable sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sel_mux_data_in  <= '0;
      sel_mux_data_out <= '0;
      wr_sel_valid     <= 1'b0;
      rd_sel_valid     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values regardless of statement order.
      wr_sel_valid <= wr_en;
      rd_sel_valid <= rd_go;
      if (wr_en) sel_mux_data_in  <= seg;
      if (rd_go) sel_mux_data_out <= seg;
    end
  end

`ifdef MEMORY_CTRL_V1_CONFLICT_EN
  always_ff @(posedge clk) begin
    if (!rst) conflict <= 1'b0;
    else      conflict <= wr_en & rd_en;
  end
`endif

endmodule

// File: tb/tb_memory_ctrl_v1.sv
// Directed, table-driven bench for memory_ctrl_v1 select registers.
// Honours MEMORY_CTRL_V1_CONFLICT_EN when the design is built with it.
module tb_memory_ctrl_v1;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [9:0] addr;
  logic [4:0] sel_mux_data_in;
  logic [4:0] sel_mux_data_out;
  logic       wr_sel_valid;
  logic       rd_sel_valid;
`ifdef MEMORY_CTRL_V1_CONFLICT_EN
  logic       conflict;
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_ctrl_v1 dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .addr             (addr),
    .sel_mux_data_in  (sel_mux_data_in),
    .sel_mux_data_out (sel_mux_data_out),
    .wr_sel_valid     (wr_sel_valid),
    .rd_sel_valid     (rd_sel_valid)
`ifdef MEMORY_CTRL_V1_CONFLICT_EN
    ,
    .conflict         (conflict)
`endif
  );

  typedef struct {
    string      name;
    logic       rst;
    logic       wr;
    logic       rd;
    logic [9:0] addr;
    logic [4:0] exp_in;
    logic [4:0] exp_out;
    logic       exp_wv;
    logic       exp_rv;
    logic       exp_conf;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [9:0] a);
    @(negedge clk);
    rst = r; wr_en = w; rd_en = rd; addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic [4:0] e_in, input logic [4:0] e_out,
                            input logic e_wv, input logic e_rv, input logic e_conf);
    check({name, ".sel_in"},  int'(sel_mux_data_in),  int'(e_in));
    check({name, ".sel_out"}, int'(sel_mux_data_out), int'(e_out));
    check({name, ".wr_v"},    int'(wr_sel_valid),     int'(e_wv));
    check({name, ".rd_v"},    int'(rd_sel_valid),     int'(e_rv));
`ifdef MEMORY_CTRL_V1_CONFLICT_EN
    check({name, ".conflict"}, int'(conflict), int'(e_conf));
`else
    if (e_conf) check({name, ".conflict_unexpected"}, 1, 0);
`endif
  endtask

  vec_t vecs[$];

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; addr = '0;

    // Expected values hand-derived: segment = ~addr[9:5].
    vecs.push_back('{"reset0",   1'b0, 1'b1, 1'b1, 10'h155, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"reset1",   1'b0, 1'b1, 1'b1, 10'h155, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"wr_020",   1'b1, 1'b1, 1'b0, 10'h020, 5'd30, 5'd0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"wr_01f",   1'b1, 1'b1, 1'b0, 10'h01F, 5'd31, 5'd0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"wr_3ff",   1'b1, 1'b1, 1'b0, 10'h3FF, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0});
    vecs.push_back('{"hold_wr",  1'b1, 1'b0, 1'b0, 10'h000, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"rd_000",   1'b1, 1'b0, 1'b1, 10'h000, 5'd0,  5'd31, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"idle_x",   1'b1, 1'b0, 1'b0, 10'bx,   5'd0,  5'd31, 1'b0, 1'b0, 1'b0});
    if (CONF_EN)
      vecs.push_back('{"both_2a0", 1'b1, 1'b1, 1'b1, 10'h2A0, 5'd10, 5'd31, 1'b1, 1'b0, 1'b1});
    else
      vecs.push_back('{"both_2a0", 1'b1, 1'b1, 1'b1, 10'h2A0, 5'd10, 5'd10, 1'b1, 1'b1, 1'b0});
    vecs.push_back('{"rd_155",   1'b1, 1'b0, 1'b1, 10'h155, 5'd10, 5'd21, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{"wr_1a5",   1'b1, 1'b1, 1'b0, 10'h1A5, 5'd18, 5'd21, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{"rst_acc",  1'b0, 1'b1, 1'b1, 10'h3E0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});
    vecs.push_back('{"post_rst", 1'b1, 1'b0, 1'b0, 10'h3E0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].addr);
      check_outs(vecs[i].name, vecs[i].exp_in, vecs[i].exp_out,
                 vecs[i].exp_wv, vecs[i].exp_rv, vecs[i].exp_conf);
    end

    // Back-to-back reads across a segment boundary, then one idle cycle.
    step(1'b1, 1'b0, 1'b1, 10'h3E0);
    check_outs("seq_rd_3e0", 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 10'h3DF);
    check_outs("seq_rd_3df", 5'd0, 5'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 10'h000);
    check_outs("seq_idle", 5'd0, 5'd1, 1'b0, 1'b0, 1'b0);

    // Simultaneous access directly followed by a lone write: conflict must drop.
    step(1'b1, 1'b1, 1'b1, 10'h0C0);
    if (CONF_EN) check_outs("seq_both_0c0", 5'd25, 5'd1, 1'b1, 1'b0, 1'b1);
    else         check_outs("seq_both_0c0", 5'd25, 5'd25, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 10'h3A0);
    if (CONF_EN) check_outs("seq_wr_3a0", 5'd2, 5'd1, 1'b1, 1'b0, 1'b0);
    else         check_outs("seq_wr_3a0", 5'd2, 5'd25, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_ctrl_v1.md
MEMORY_CTRL_V1 -- requirements
Module: memory_ctrl_v1

Interface
REQ-001 The block SHALL use parameter ADDR_W, default 10, as the word-address width.
REQ-002 The block SHALL use parameter SEL_W, default 5, as the segment-select width; segment size SHALL be 2**(ADDR_W-SEL_W) words (32 at defaults).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port wr_en, input, 1 bit: write request for the current addr.
REQ-006 The block SHALL have port rd_en, input, 1 bit: read request for the current addr.
REQ-007 The block SHALL have port addr, input, ADDR_W bits: word address.
REQ-008 The block SHALL have port sel_mux_data_in, output, SEL_W bits: segment select for the write-data mux.
REQ-009 The block SHALL have port sel_mux_data_out, output, SEL_W bits: segment select for the read-data mux.
REQ-010 The block SHALL have port wr_sel_valid, output, 1 bit: sel_mux_data_in reflects a write accepted last cycle.
REQ-011 The block SHALL have port rd_sel_valid, output, 1 bit: sel_mux_data_out reflects a read accepted last cycle.

Function
REQ-012 Segment index SHALL be the bitwise inverse of addr[ADDR_W-1:ADDR_W-SEL_W], so the top segment (0x3E0-0x3FF) is segment 0 and 0x000-0x01F is segment 31.
REQ-013 When wr_en=1 on a rising edge, sel_mux_data_in SHALL load the segment index of addr and wr_sel_valid SHALL be 1 the following cycle (latency 1).
REQ-014 When rd_en=1 on a rising edge, sel_mux_data_out SHALL load the segment index of addr and rd_sel_valid SHALL be 1 the following cycle (latency 1).
REQ-015 When wr_en=0, sel_mux_data_in SHALL hold its value and wr_sel_valid SHALL be 0 next cycle; likewise for rd_en, sel_mux_data_out and rd_sel_valid.
REQ-016 With wr_en=1 and rd_en=1 together, both selects SHALL load the same segment index and both valids SHALL assert, unless REQ-021 applies.
REQ-017 An X/unknown addr with both enables 0 SHALL NOT change either select.
REQ-018 Outputs SHALL be registered only; no combinational path from inputs to outputs.

Reset
REQ-019 With rst=0 on a rising edge, sel_mux_data_in and sel_mux_data_out SHALL become 0 and both valids SHALL become 0, overriding any simultaneous wr_en/rd_en.
REQ-020 An access whose enable is sampled on the same edge as rst=0 SHALL be discarded; no access SHALL be issued for it after reset releases.

Configuration
REQ-021 With macro MEMORY_CTRL_V1_CONFLICT_EN defined, the block SHALL add an output conflict (1 bit, registered, reset 0) that is 1 the cycle after wr_en=1 and rd_en=1 coincide; write SHALL take priority: sel_mux_data_in and wr_sel_valid update, sel_mux_data_out holds, and rd_sel_valid is 0. Without the macro, the conflict port SHALL NOT exist and REQ-016 applies.

Structure
REQ-022 Package memory_ctrl_pkg SHALL hold ADDR_W/SEL_W defaults, the segment-size constant, and a function mapping an address to a segment index.
REQ-023 The decode SHALL live in one sub-module, memory_seg_decoder (combinational addr -> segment index), instantiated once and shared by both select registers.

Verification
REQ-024 Reset: hold rst=0 for 2 cycles with wr_en=rd_en=1 and addr=0x155 -> both selects 0, both valids 0.
REQ-025 Top segment write: addr=0x3FF, wr_en=1 -> next cycle sel_mux_data_in=0, wr_sel_valid=1, sel_mux_data_out unchanged.
REQ-026 Bottom segment read: addr=0x000, rd_en=1 -> next cycle sel_mux_data_out=31, rd_sel_valid=1.
REQ-027 Segment boundary: writes to addr=0x020 then 0x01F -> sel_mux_data_in=30 then 31.
REQ-028 Hold: after a write to 0x3FF, set wr_en=0 and addr=0x000 -> sel_mux_data_in stays 0, wr_sel_valid=0.
REQ-029 Simultaneous: addr=0x2A0, wr_en=rd_en=1 -> both selects 10, both valids 1 without the macro; with MEMORY_CTRL_V1_CONFLICT_EN: sel_mux_data_in=10, sel_mux_data_out held, rd_sel_valid=0, conflict=1.
